// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (IF) and load/store (LS).
// Fixed LS priority with IF anti-starvation; one transaction in flight: IDLE->ISSUE->WAIT->RESP.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int SC_W   = $clog2(STARVE_MAX + 1);
  localparam int WC_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SC_W-1:0]     starve_cnt;
  logic [WC_W-1:0]     wait_cnt;
  logic                owner_ls;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [MASK_W-1:0]   lat_wmask;
  logic                ls_win;
  logic                wait_last;

  // LS loses a contested cycle only once IF has been passed over STARVE_MAX times.
  assign ls_win    = ls_req && !(if_req && (starve_cnt == SC_W'(STARVE_MAX)));
  assign wait_last = (wait_cnt == WC_W'(MEM_LAT - 1));

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_wmask = lat_wmask;

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (ls_win) begin
          ls_gnt    = 1'b1;
          state_nxt = ISSUE;
        end else if (if_req) begin
          if_gnt    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_last) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if_rvalid = !owner_ls;
        ls_rvalid = owner_ls;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_ls  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end else if (ls_gnt) begin
      owner_ls  <= 1'b1;
      lat_we    <= ls_we;
      lat_addr  <= ls_addr;
      lat_wdata <= ls_wdata;
      lat_wmask <= ls_wmask;
    end else if (if_gnt) begin
      owner_ls  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= if_addr;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end
  end

  // Only contested LS grants count toward IF starvation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (ls_gnt && if_req && (starve_cnt != SC_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + WC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= '0;
      ls_rdata <= '0;
    end else if ((state == WAIT) && wait_last && !lat_we) begin
      if (owner_ls) begin
        ls_rdata <= mem_rdata;
      end else begin
        if_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } ls_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wmask;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'h00A00093 : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  // Memory environment: write on mem_en, read data valid exactly LAT cycles after sample.
  logic [31:0] ram [16];
  logic [31:0] pd  [LAT];
  logic        pv  [LAT];
  wire  [3:0]  widx = mem_addr[5:2];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[widx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    pd[0] <= ram[widx];
    pv[0] <= rst && mem_en && !mem_we;
    for (int i = 1; i < LAT; i++) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
  end
  assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hDEAD0BAD;

  // Reference model: transaction-level timeline relative to the grant cycle t0.
  logic [31:0] if_q [$];
  ls_t         ls_q [$];
  bit          if_off, ls_off;
  bit          act, m_ls, m_we;
  int          t0, cyc, starve;
  logic [31:0] m_addr, m_wdata, e_if_rd, e_ls_rd;
  logic [3:0]  m_mask;
  logic [31:0] shadow [16];
  int          errors, checks, ngr;
  logic [9:0]  order;
  int          en_cyc [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    act = 0; starve = 0; m_ls = 0; m_we = 0;
    m_addr = 0; m_wdata = 0; m_mask = 0; e_if_rd = 0; e_ls_rd = 0;
    for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
  endtask

  task automatic drive();
    if_req   = (if_q.size() != 0) && !if_off;
    if_addr  = if_req ? if_q[0] : 32'h0;
    ls_req   = (ls_q.size() != 0) && !ls_off;
    ls_we    = ls_req ? ls_q[0].we : 1'b0;
    ls_addr  = ls_req ? ls_q[0].addr : 32'h0;
    ls_wdata = ls_req ? ls_q[0].wdata : 32'h0;
    ls_wmask = ls_req ? ls_q[0].mask : 4'h0;
  endtask

  // Called at a negedge; checks one cycle and advances the model across the posedge.
  task automatic cycle();
    bit   eg_if, eg_ls, een, resp;
    ls_t  r;
    drive();
    #1;
    eg_ls = !act && ls_req && !(if_req && starve == SMAX);
    eg_if = !act && if_req && !eg_ls;
    een   = act && (cyc == t0 + 1);
    resp  = act && (cyc == t0 + LAT + 2);
    if (resp && !m_we) begin
      if (m_ls) e_ls_rd = shadow[m_addr[5:2]];
      else      e_if_rd = shadow[m_addr[5:2]];
    end
    chk("if_gnt", if_gnt, eg_if);
    chk("ls_gnt", ls_gnt, eg_ls);
    chk("busy", busy, act);
    chk("mem_en", mem_en, een);
    chk("mem_we", mem_we, een && m_we);
    chk("if_rvalid", if_rvalid, resp && !m_ls);
    chk("ls_rvalid", ls_rvalid, resp && m_ls);
    chk("if_rdata", if_rdata, e_if_rd);
    chk("ls_rdata", ls_rdata, e_ls_rd);
    chk("mem_addr", mem_addr, m_addr);
    if (m_ls) begin
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wmask", mem_wmask, m_mask);
    end
    if (if_gnt || ls_gnt) begin
      if (ngr < 10) order[9-ngr] = if_gnt;
      ngr++;
    end
    if (mem_en) en_cyc.push_back(cyc);
    @(posedge clk);
    if (resp) act = 0;
    if (eg_ls) begin
      r = ls_q.pop_front();
      act = 1; t0 = cyc; m_ls = 1; m_we = r.we;
      m_addr = r.addr; m_wdata = r.wdata; m_mask = r.mask;
      if (if_req && starve < SMAX) starve++;
      if (r.we)
        for (int b = 0; b < 4; b++)
          if (r.mask[b]) shadow[r.addr[5:2]][8*b +: 8] = r.wdata[8*b +: 8];
    end else if (eg_if) begin
      act = 1; t0 = cyc; m_ls = 0; m_we = 0;
      m_addr = if_q.pop_front();
      starve = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int maxc);
    int n;
    n = 0;
    while ((if_q.size() != 0 || ls_q.size() != 0 || act) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain", (if_q.size() != 0 || ls_q.size() != 0 || act), 0);
  endtask

  initial begin
    logic [31:0] w;
    errors = 0; checks = 0; cyc = 0; t0 = 0; ngr = 0; order = '0;
    if_off = 0; ls_off = 0;
    rst = 1'b0;
    drive();
    mreset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single IF read of preloaded word.
    if_q.push_back(32'h10);
    run(50);
    chk("t1_if_rdata", if_rdata, 32'h00A00093);

    // LS write, then read back through LS.
    ls_q.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'hDEADBEEF, mask: 4'b0011});
    run(50);
    chk("t2_ls_rdata_kept", ls_rdata, 0);
    ls_q.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0, mask: 4'h0});
    run(50);
    w = init_word(8);
    chk("t2_readback", ls_rdata, {w[31:16], 16'hBEEF});

    // Simultaneous requests with no starvation history.
    ngr = 0; order = '0;
    if_q.push_back(32'h8);
    ls_q.push_back('{we: 1'b0, addr: 32'hC, wdata: 32'h0, mask: 4'h0});
    run(50);
    chk("t3_first_ls", order[9], 0);
    chk("t3_then_if", order[8], 1);

    // Permanent contention: IF wins every fifth grant.
    ngr = 0; order = '0;
    for (int i = 0; i < 8; i++)
      ls_q.push_back('{we: 1'(i & 1), addr: 32'(i) << 2, wdata: $urandom, mask: 4'(i)});
    if_q.push_back(32'h4);
    if_q.push_back(32'h18);
    run(200);
    chk("t4_order", order, 10'b0000100001);

    // Back-to-back IF reads.
    en_cyc.delete();
    if_q.push_back(32'h0);
    if_q.push_back(32'h4);
    run(50);
    chk("t6_en_count", en_cyc.size(), 2);
    if (en_cyc.size() == 2) chk("t6_en_gap", en_cyc[1] - en_cyc[0], LAT + 3);

    // Reset during WAIT of an LS read.
    ls_q.push_back('{we: 1'b0, addr: 32'h30, wdata: 32'h0, mask: 4'h0});
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (act && cyc == t0 + 2) break;
    end
    chk("t5_in_wait", busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_mem_en", mem_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ls_rvalid", ls_rvalid, 0);
    chk("t5_ls_gnt", ls_gnt, 0);
    chk("t5_ls_rdata", ls_rdata, 0);
    if_q.delete(); ls_q.delete();
    mreset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) cycle();

    // Randomized traffic with legal request withdrawals.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && if_q.size() < 3)
        if_q.push_back(32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0 && ls_q.size() < 3)
        ls_q.push_back('{we: 1'($urandom_range(0, 1)), addr: 32'($urandom_range(0, 15)) << 2,
                         wdata: $urandom, mask: 4'($urandom_range(0, 15))});
      if (!act && $urandom_range(0, 15) == 0 && if_q.size() != 0) begin
        void'(if_q.pop_front());
        if_off = 1;
      end
      if (!act && $urandom_range(0, 15) == 0 && ls_q.size() != 0) begin
        void'(ls_q.pop_front());
        ls_off = 1;
      end
      cycle();
      if_off = 0;
      ls_off = 0;
    end
    run(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
